mips_mem_responder: RTL

- Data-memory responder at the far end of the CPU MEM-stage load/store interface; the CPU pipeline is the initiator.
- Accepts one word or byte-lane request at a time and answers after a programmable latency.
- Holds the pipeline with `stall` while a request is outstanding.
- Exposes `edit_serial`, a running count of completed writes, for bench monitoring alongside returned data.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mips_mem_array.sv | 30 +++
 rtl/mips_mem_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Types shared by the data-memory responder and the CPU MEM-stage initiator.
package mips_mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   localparam int WORD_BYTES = 4;
   localparam int REQ_ADDR_W = 32;

   typedef struct packed {
      logic                  write;
      logic [REQ_ADDR_W-1:0] addr;
      logic [WORD_BYTES-1:0] be;
      logic [31:0]           wdata;
   } mem_req_t;

endpackage

// File: rtl/mips_mem_array.sv
// Single-port word RAM: synchronous per-byte write, combinational read.
module mips_mem_array
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [WORD_BYTES-1:0] be_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_mem_responder.sv
// Data-memory responder: one outstanding load/store answered LATENCY cycles after
// acceptance, with the MEM stage held on stall until the response pulse.
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DEPTH    = 1024,
   parameter int LATENCY  = 3,
   parameter int SERIAL_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [3:0]            req_be,
   input  logic [31:0]           req_wdata,
   output logic                  stall,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [SERIAL_W-1:0]   edit_serial
);

   localparam int         OFF_W    = $clog2(WORD_BYTES);
   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   mem_req_t              req_q, req_d, cur_req;
   logic                  accept;
   logic [ADDR_W-1:0]     cur_addr;
   logic [ADDR_W-OFF_W-1:0] cur_widx;
   logic                  cur_err;
   logic                  mem_we;
   logic [31:0]           mem_rdata;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic [SERIAL_W-1:0]   serial_q, serial_d;

   // In IDLE the incoming request is the one being judged, so LATENCY==1 can
   // answer straight from the port; otherwise the latched copy is used.
   always_comb begin
      if (state_q == IDLE) begin
         cur_req.write = req_write;
         cur_req.addr  = REQ_ADDR_W'(req_addr);
         cur_req.be    = req_be;
         cur_req.wdata = req_wdata;
      end else begin
         cur_req = req_q;
      end
   end

   assign accept   = (state_q == IDLE) && req_valid && enable;
   assign req_d    = cur_req;
   assign cur_addr = ADDR_W'(cur_req.addr);
   assign cur_widx = cur_addr[ADDR_W-1:OFF_W];
   assign cur_err  = (cur_addr[OFF_W-1:0] != '0) || (64'(cur_widx) >= 64'(DEPTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (enable) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Response registers load on the edge entering RESP so data is valid with the pulse;
   // the store and the serial bump happen on the edge leaving RESP.
   always_comb begin
      stall        = 1'b0;
      mem_we       = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      serial_d     = serial_q;
      unique case (state_q)
         IDLE: stall = req_valid;
         WAIT: stall = 1'b1;
         RESP: begin
            mem_we = req_q.write && !cur_err;
            if (mem_we) serial_d = serial_q + SERIAL_W'(1);
         end
         default: stall = 1'b0;
      endcase
      if (state_d == RESP) begin
         resp_valid_d = 1'b1;
         resp_err_d   = cur_err;
         resp_rdata_d = (cur_req.write || cur_err) ? '0 : mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         serial_q     <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         serial_q     <= serial_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) req_q <= req_d;
   end

   mips_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .be_i    (req_q.be),
      .addr_i  (cur_addr[AW+OFF_W-1:OFF_W]),
      .wdata_i (req_q.wdata),
      .rdata_o (mem_rdata)
   );

   assign resp_valid  = resp_valid_q;
   assign resp_err    = resp_err_q;
   assign resp_rdata  = resp_rdata_q;
   assign edit_serial = serial_q;

endmodule
